e203_exu_wbck_arb: RTL
======================

# e203_exu_wbck_arb

Parametrised NSRC-source write-back arbiter for the E203 EXU, replacing the fixed two-source (ALU + long-pipe) write-back mux. Selects one pending write-back per cycle by fixed-priority or round-robin policy, drives the integer regfile write port through an optional output register, and keeps a sticky accumulated exception-flags register for the long-pipe (FPU/div) sources. Sits between the ALU/long-pipe write-back producers and the regfile / CSR flag logic.

## Interface
- NSRC, 2, number of write-back sources (2..8); index 0 = ALU, higher = long-pipe units
- XLEN, 32, write data width
- RFIDX_W, 5, regfile index width
- FLAGS_W, 5, exception-flag width per source
- RR_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin
- clk  input  1  core clock, all state rises on posedge
- rst_n  input  1  asynchronous active-low reset
- src_valid  input  NSRC  per-source write-back request
- src_ready  output  NSRC  per-source grant; transfer when valid & ready
- src_wdat  input  NSRC*XLEN  packed write data, source i at [i*XLEN +: XLEN]
- src_rdidx  input  NSRC*RFIDX_W  packed destination index
- src_flags  input  NSRC*FLAGS_W  packed exception flags (source 0 flags ignored, treated as 0)
- wbck_stall  input  1  blocks all acceptance this cycle
- rf_wbck_o_ena  output  1  regfile write enable
- rf_wbck_o_wdat  output  XLEN  regfile write data
- rf_wbck_o_rdidx  output  RFIDX_W  regfile write index
- fflags_clr  input  1  clears sticky flags
- fflags_o  output  FLAGS_W  sticky accumulated flags

## Operation
- Grant: at most one bit of src_ready high per cycle; src_ready all 0 when wbck_stall=1 or no valid. Ready depends combinationally on src_valid and arbiter state only, never on its own source's data.
- Fixed priority (RR_MODE=0): highest-index valid source granted.
- Round-robin (RR_MODE=1): 3-bit last-grant pointer ptr; search starts at (ptr+1) mod NSRC and wraps; on a transfer ptr <= granted index; no transfer leaves ptr unchanged. Wrap: ptr=NSRC-1 searches from 0.
- Transfer captures winner's wdat/rdidx; rdidx=0 is forwarded unchanged (regfile discards x0).
- Sticky flags: on transfer from source i>0, fflags_o <= fflags_o | flags_i. fflags_clr with simultaneous transfer: fflags_o <= flags_i (clear applies to old value, new flags kept). fflags_clr alone: fflags_o <= 0.
- No internal buffering beyond the output register; a non-granted source must hold valid and data stable until granted.
- Reset: rf_wbck_o_ena=0, rf_wbck_o_wdat=0, rf_wbck_o_rdidx=0, fflags_o=0, ptr=NSRC-1 (first RR search starts at 0). Reset asserted mid-operation discards any registered write-back; no write issued after reset.

## Timing
- With output register: transfer in cycle N -> rf_wbck_o_ena=1 in cycle N+1 for exactly one cycle, wdat/rdidx valid with it; ena=0 in any cycle following a cycle with no transfer. Throughput one write-back per cycle, back-to-back.
- Without output register: rf_wbck_o_ena = OR(src_valid & src_ready), same cycle, data muxed combinationally.
- fflags_o updates in the cycle after the transfer in both modes (always registered).
- ptr updates at the clock edge ending the transfer cycle; wbck_stall cycles do not advance ptr.

## Configuration
- E203_WBCK_OREG_EN defined: output register present, 1-cycle latency as above, outputs reset to 0.
- E203_WBCK_OREG_EN undefined: no output register, 0-cycle latency, rf_wbck_o_* purely combinational; rf_wbck_o_wdat/rdidx = 0 when ena=0. Arbitration, ptr and fflags_o behaviour identical in both builds.

## Test plan
- Fixed priority, NSRC=2, both valid, src0 wdat=0x11 rd=3, src1 wdat=0x22 rd=5 flags=0x04 -> ready=2'b10, next cycle ena=1 wdat=0x22 rd=5, fflags_o=0x04; then src0 granted following cycle, ena with 0x11 rd=3.
- Round-robin, NSRC=4, all valid held 6 cycles after reset -> grant order 0,1,2,3,0,1; ptr wrap from 3 to 0 verified.
- wbck_stall=1 for 2 cycles with src1 valid -> src_ready=0, ena=0 one cycle after stall onset, ptr unchanged; stall release -> src1 granted, ena next cycle.
- Flags: src1 transfers flags=0x01, then src2 flags=0x10 -> fflags_o=0x11; fflags_clr together with src1 flags=0x02 -> fflags_o=0x02; fflags_clr alone -> 0x00.
- Reset mid-operation: transfer in cycle N, rst_n low in N+1 before edge -> ena=0, wdat=0, rdidx=0, fflags_o=0; after release first RR grant goes to lowest valid index from 0.
- Build without E203_WBCK_OREG_EN: src0 valid wdat=0xDEADBEEF rd=7 -> ena=1 same cycle with that data; no valid -> ena=0, wdat=0, rdidx=0.

Source files
------------

// File: rtl/e203_exu_wbck_arb.sv
// NSRC-source EXU write-back arbiter (fixed priority or round-robin) with sticky exception flags.
// Define E203_WBCK_OREG_EN to register the regfile write port (1-cycle latency).
module e203_exu_wbck_arb #(
  parameter int unsigned NSRC    = 2,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RFIDX_W = 5,
  parameter int unsigned FLAGS_W = 5,
  parameter int unsigned RR_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NSRC-1:0]         src_valid,
  output logic [NSRC-1:0]         src_ready,
  input  logic [NSRC*XLEN-1:0]    src_wdat,
  input  logic [NSRC*RFIDX_W-1:0] src_rdidx,
  input  logic [NSRC*FLAGS_W-1:0] src_flags,
  input  logic                    wbck_stall,
  output logic                    rf_wbck_o_ena,
  output logic [XLEN-1:0]         rf_wbck_o_wdat,
  output logic [RFIDX_W-1:0]      rf_wbck_o_rdidx,
  input  logic                    fflags_clr,
  output logic [FLAGS_W-1:0]      fflags_o
);

  logic [2:0]         r_ptr;
  logic [FLAGS_W-1:0] r_fflags;
  logic [2:0]         w_sel;
  logic               w_found;
  logic [NSRC-1:0]    w_grant;
  logic [XLEN-1:0]    w_wdat;
  logic [RFIDX_W-1:0] w_rdidx;
  logic [FLAGS_W-1:0] w_flags;
  logic               w_unused_flags0;

  // ALU flags never contribute to the sticky register.
  assign w_unused_flags0 = ^src_flags[FLAGS_W-1:0];

  // Each valid source gets a distance from the search start; the smallest wins.
  // Fixed priority maps the highest index to distance 0.
  always_comb begin : arb
    int unsigned best_d;
    int unsigned d;
    best_d  = NSRC;
    d       = 0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (RR_MODE != 0) d = (i + NSRC - 1 - 32'(r_ptr)) % NSRC;
      else              d = NSRC - 1 - i;
      if (src_valid[i] && !wbck_stall && (d < best_d)) begin
        best_d  = d;
        w_sel   = i[2:0];
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_grant = '0;
    w_wdat  = '0;
    w_rdidx = '0;
    w_flags = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (w_found && (w_sel == i[2:0])) begin
        w_grant[i] = 1'b1;
        w_wdat     = src_wdat[i*XLEN +: XLEN];
        w_rdidx    = src_rdidx[i*RFIDX_W +: RFIDX_W];
        if (i != 0) w_flags = src_flags[i*FLAGS_W +: FLAGS_W];
      end
    end
  end

  assign src_ready = w_grant;
  assign fflags_o  = r_fflags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= 3'(NSRC - 1);
      r_fflags <= '0;
    end else begin
      if (w_found) begin
        r_ptr    <= w_sel;
        // A clear in the same cycle wipes only the old value, not the incoming flags.
        r_fflags <= (fflags_clr ? '0 : r_fflags) | w_flags;
      end else if (fflags_clr) begin
        r_fflags <= '0;
      end
    end
  end

`ifdef E203_WBCK_OREG_EN
  logic               r_ena;
  logic [XLEN-1:0]    r_wdat;
  logic [RFIDX_W-1:0] r_rdidx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ena   <= 1'b0;
      r_wdat  <= '0;
      r_rdidx <= '0;
    end else begin
      r_ena <= w_found;
      if (w_found) begin
        r_wdat  <= w_wdat;
        r_rdidx <= w_rdidx;
      end
    end
  end

  assign rf_wbck_o_ena   = r_ena;
  assign rf_wbck_o_wdat  = r_wdat;
  assign rf_wbck_o_rdidx = r_rdidx;
`else
  assign rf_wbck_o_ena   = w_found;
  assign rf_wbck_o_wdat  = w_wdat;
  assign rf_wbck_o_rdidx = w_rdidx;
`endif

endmodule
